// File: rtl/bus_pkg.sv
// Shared encodings for the two-master serial bus arbiter.
package bus_pkg;

   // Arbiter FSM state codes; these also drive the board LEDs.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GNT_M1 = 3'd1,
      GNT_M2 = 3'd2
   } arb_state_t;

   // Master identifiers used for split ownership.
   typedef logic [1:0] master_t;
   localparam master_t NONE = 2'd0;
   localparam master_t M1   = 2'd1;
   localparam master_t M2   = 2'd2;

   // Default hold limit and a counter width that satisfies 2^TW > TIMEOUT.
   localparam int TIMEOUT_DEFAULT = 64;
   localparam int TW_DEFAULT      = 7;

endpackage

// File: rtl/bus_arbiter_hold_timer.sv
// Hold timer: counts consecutive granted cycles and flags the last allowed one.
module hold_timer
   import bus_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int TW      = TW_DEFAULT      // must satisfy 2^TW > TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] count;

   // Count granted cycles; clear has priority so every grant starts from zero.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all registered state so every flop
      // samples pre-edge values regardless of block ordering.
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TW'(1);
      end
   end

   // The current granted cycle is the TIMEOUT-th one.
   assign expired = enable && (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master fixed-priority (M1 > M2) bus arbiter with one outstanding split
// transaction and a hold timer that reclaims a bus a master fails to release.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int TW      = TW_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m1_req,
   input  logic       m2_req,
   input  logic       m1_done,
   input  logic       m2_done,
   input  logic       split,
   input  logic       split_ready,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic       split_allow,
   output logic       bus_busy,
   output logic       timeout_err,
   output logic [2:0] arbiter_state
);

   arb_state_t state,       state_nxt;
   logic       split_pend,  split_pend_nxt;
   master_t    split_owner, split_owner_nxt;
   logic       rdy_q,       rdy_q_nxt;
   logic       timeout_err_nxt;
   logic       expired;
   logic       own_done;
   master_t    own_id;

   hold_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_hold_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (~bus_busy),
      .enable  (bus_busy),
      .expired (expired)
   );

   // Identify the current bus owner and whether it is releasing this cycle.
   always_comb begin
      own_done = 1'b0;
      own_id   = NONE;
      if (state == GNT_M1) begin
         own_done = m1_done;
         own_id   = M1;
      end else if (state == GNT_M2) begin
         own_done = m2_done;
         own_id   = M2;
      end
   end

   // Next-state arbitration plus split bookkeeping and timeout detection.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt       = state;
      split_pend_nxt  = split_pend;
      split_owner_nxt = split_owner;
      rdy_q_nxt       = rdy_q;
      timeout_err_nxt = 1'b0;

      // A resume notice only means something while a split is outstanding.
      if (split_pend && split_ready) begin
         rdy_q_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (split_pend && rdy_q) begin
               if (split_owner == M1) state_nxt = GNT_M1;
               else                   state_nxt = GNT_M2;
               split_pend_nxt  = 1'b0;
               split_owner_nxt = NONE;
               rdy_q_nxt       = 1'b0;
            end else if (m1_req && (split_owner != M1)) begin
               state_nxt = GNT_M1;
            end else if (m2_req && (split_owner != M2)) begin
               state_nxt = GNT_M2;
            end
         end

         GNT_M1, GNT_M2: begin
            // Release beats split, split beats timeout.
            if (own_done) begin
               state_nxt = IDLE;
            end else if (split && !split_pend) begin
               state_nxt       = IDLE;
               split_pend_nxt  = 1'b1;
               split_owner_nxt = own_id;
            end else if (expired) begin
               state_nxt       = IDLE;
               timeout_err_nxt = 1'b1;
            end
         end

         // Codes 3..7 recover to IDLE.
         default: state_nxt = IDLE;
      endcase
   end

   // State and bookkeeping registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         split_pend  <= 1'b0;
         split_owner <= NONE;
         rdy_q       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         split_pend  <= split_pend_nxt;
         split_owner <= split_owner_nxt;
         rdy_q       <= rdy_q_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

   assign m1_grant      = (state == GNT_M1);
   assign m2_grant      = (state == GNT_M2);
   assign bus_busy      = m1_grant | m2_grant;
   assign split_allow   = ~split_pend;
   assign arbiter_state = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed stimulus pushes expected output
// vectors tagged with their cycle; a monitor pops and compares on negedges.
module tb_bus_arbiter;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset, m1_req, m2_req, m1_done, m2_done, split, split_ready;
   logic       m1_grant, m2_grant, split_allow, bus_busy, timeout_err;
   logic [2:0] arbiter_state;

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT(TO), .TW(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .m1_req        (m1_req),
      .m2_req        (m2_req),
      .m1_done       (m1_done),
      .m2_done       (m2_done),
      .split         (split),
      .split_ready   (split_ready),
      .m1_grant      (m1_grant),
      .m2_grant      (m2_grant),
      .split_allow   (split_allow),
      .bus_busy      (bus_busy),
      .timeout_err   (timeout_err),
      .arbiter_state (arbiter_state)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   cyc = 0;
   int   base = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   stim_done = 1'b0;

   // Output vector: {state, m1_grant, m2_grant, bus_busy, split_allow, timeout_err}
   wire [7:0] act = {arbiter_state, m1_grant, m2_grant, bus_busy, split_allow, timeout_err};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pack_exp(input logic [2:0] st, input bit sa, input bit te);
      logic g1, g2;
      g1 = (st == 3'd1);
      g2 = (st == 3'd2);
      return {st, g1, g2, g1 | g2, sa, te};
   endfunction

   task automatic expect_at(input int k, input string nm, input logic [2:0] st,
                            input bit sa, input bit te);
      exp_t e;
      e.cyc  = base + k;
      e.name = nm;
      e.val  = pack_exp(st, sa, te);
      sb.push_back(e);
   endtask

   // Apply one cycle of inputs, then move to just after the next edge.
   task automatic tick(input bit rst, input bit r1, input bit r2, input bit d1,
                       input bit d2, input bit sp, input bit sr);
      reset = rst; m1_req = r1; m2_req = r2;
      m1_done = d1; m2_done = d2; split = sp; split_ready = sr;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation due this cycle; flush leftovers at end.
   always @(negedge clk) begin
      while (sb.size() > 0 && (sb[0].cyc <= cyc || stim_done)) begin
         cur = sb.pop_front();
         n_tests++;
         if (cur.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: expected in cycle %0d, not observed (now cycle %0d)",
                     cur.name, cur.cyc, cyc);
         end else if (act !== cur.val) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %b required %b  [st g1 g2 busy sa terr]",
                     cur.name, cyc, act, cur.val);
         end
      end
   end

   initial begin
      tick(1, 0, 0, 0, 0, 0, 0);

      // Reset state.
      base = cyc;
      expect_at(1, "reset_state", 3'd0, 1, 0);
      tick(1, 0, 0, 0, 0, 0, 0);

      // Priority, latency, stray done ignored, release gap.
      base = cyc;
      expect_at(1, "t1_m1_priority",     3'd1, 1, 0);
      expect_at(3, "t1_other_done_ign",  3'd1, 1, 0);
      expect_at(4, "t1_release_idle",    3'd0, 1, 0);
      expect_at(5, "t1_m2_grant",        3'd2, 1, 0);
      expect_at(7, "t1_m2_release",      3'd0, 1, 0);
      tick(0, 1, 1, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 1, 0, 0);
      tick(0, 0, 1, 1, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);

      // Split by M2, M2 parked, resume after M1 releases.
      base = cyc;
      expect_at(1,  "t2_m2_grant",        3'd2, 1, 0);
      expect_at(3,  "t2_split_idle",      3'd0, 0, 0);
      expect_at(4,  "t2_m1_while_parked", 3'd1, 0, 0);
      expect_at(7,  "t2_idle_pending",    3'd0, 0, 0);
      expect_at(8,  "t2_resume_m2",       3'd2, 1, 0);
      expect_at(10, "t2_end_idle",        3'd0, 1, 0);
      tick(0, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      tick(0, 1, 1, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0, 1);
      tick(0, 0, 1, 1, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);

      // Timeout after TO granted cycles, one-cycle error, re-grant.
      base = cyc;
      expect_at(4, "t3_last_grant",    3'd1, 1, 0);
      expect_at(5, "t3_timeout_err",   3'd0, 1, 1);
      expect_at(6, "t3_regrant",       3'd1, 1, 0);
      expect_at(7, "t3_err_one_cycle", 3'd0, 1, 0);
      for (int i = 0; i < 6; i++) tick(0, 1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);

      // done + split in the same cycle: done wins, no split recorded.
      base = cyc;
      expect_at(2, "t4_done_beats_split", 3'd0, 1, 0);
      expect_at(3, "t4_no_split_pending", 3'd0, 1, 0);
      tick(0, 1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0, 1, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);

      // done in the timeout cycle: release without error.
      base = cyc;
      expect_at(4, "t4_done_at_limit", 3'd1, 1, 0);
      expect_at(5, "t4_no_err",        3'd0, 1, 0);
      expect_at(6, "t4_no_err_late",   3'd0, 1, 0);
      tick(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);

      // Stray split_ready ignored; split in the timeout cycle beats timeout.
      base = cyc;
      expect_at(1, "t5_m2_grant",          3'd2, 1, 0);
      expect_at(4, "t5_m2_at_limit",       3'd2, 1, 0);
      expect_at(5, "t5_split_beats_to",    3'd0, 0, 0);
      expect_at(6, "t5_stray_ready_ign",   3'd0, 0, 0);
      tick(0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 0, 0, 0);

      // Second split while pending is ignored; M1 keeps the bus.
      base = cyc;
      expect_at(1, "t5_m1_while_pending",  3'd1, 0, 0);
      expect_at(3, "t5_second_split_ign",  3'd1, 0, 0);
      tick(0, 1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);

      // Reset mid-grant with split pending; parked M2 is forgotten.
      base = cyc;
      expect_at(1, "t6_reset_clears",   3'd0, 1, 0);
      expect_at(2, "t6_m2_after_reset", 3'd2, 1, 0);
      expect_at(3, "t6_m2_release",     3'd0, 1, 0);
      tick(1, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);

      tick(0, 0, 0, 0, 0, 0, 0);
      stim_done = 1'b1;
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master bus arbiter for the serial bus. It grants the shared bus to master 1 or master 2 using fixed priority (M1 > M2), and supports one outstanding split transaction from a slave. A hold timer forcibly reclaims a bus that a master fails to release. Its `arbiter_state` output drives board LEDs through the top wrapper.

Parameters:
- TIMEOUT, 64: maximum number of consecutive granted cycles before a forced release.
- TW, 7: width of the hold counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  system clock (divided board clock).
- reset  input  1  synchronous, active-high reset.
- m1_req  input  1  master 1 bus request; level, held until granted.
- m2_req  input  1  master 2 bus request; level, held until granted.
- m1_done  input  1  master 1 releases the bus; 1-cycle pulse.
- m2_done  input  1  master 2 releases the bus; 1-cycle pulse.
- split  input  1  addressed slave splits the current transaction; 1-cycle pulse.
- split_ready  input  1  split slave is ready to resume; 1-cycle pulse.
- m1_grant  output  1  bus granted to master 1 (registered).
- m2_grant  output  1  bus granted to master 2 (registered).
- split_allow  output  1  1 when no split is outstanding; slaves must not assert split while this is 0.
- bus_busy  output  1  m1_grant OR m2_grant.
- timeout_err  output  1  1-cycle pulse on a forced release.
- arbiter_state  output  3  current FSM state code.

Behaviour:
- Reset is synchronous. On reset:
  - state = IDLE;
  - grants = 0, timeout_err = 0, split_allow = 1;
  - split_pend = 0, split_owner = NONE, rdy_q = 0, hold counter = 0.
- FSM states:
  - IDLE = 3'd0, GNT_M1 = 3'd1, GNT_M2 = 3'd2;
  - codes 3..7 are illegal and return to IDLE on the next cycle.
- Grant outputs are Moore outputs decoded from state; exactly one grant (or none) is high at any time.
- IDLE arbitration, evaluated each cycle in this priority order:
  1. split_pend = 1 and rdy_q = 1: grant split_owner; clear split_pend, rdy_q and split_owner.
  2. m1_req = 1 and M1 is not parked: go to GNT_M1.
  3. m2_req = 1 and M2 is not parked: go to GNT_M2.
  4. Otherwise stay in IDLE.
- A master is "parked" when it is split_owner; its req is ignored until it is resumed.
- Latency: a request seen in IDLE in cycle N gives a grant high in cycle N+1.
- Release:
  - the granted master's done in cycle N sets grant low in N+1 (state IDLE);
  - at least one IDLE cycle always separates two grants;
  - done from the non-granted master is ignored.
- Split:
  - split in GNT_Mx with split_pend = 0 and no done that cycle: go to IDLE, split_owner = x, split_pend = 1, split_allow = 0 from the next cycle;
  - split in IDLE is ignored;
  - split while split_pend = 1 is a protocol violation and is ignored.
- split_ready:
  - sets rdy_q only while split_pend = 1; otherwise ignored;
  - may arrive while the other master is granted; resumption waits for IDLE.
- Hold counter:
  - cleared on entry to any GNT state;
  - increments each granted cycle.
- Timeout: when the counter reaches TIMEOUT-1 and no done/split occurs that cycle:
  - go to IDLE;
  - timeout_err = 1 for the following cycle only;
  - the master's req is then re-arbitrated normally.
- Same-cycle conflicts:
  - done + split: done wins and the split is ignored;
  - done + timeout: done wins and no error is raised;
  - split + timeout: split wins.
- reset mid-grant or mid-split: all state is cleared and the parked master is forgotten.

Decomposition:
- Package bus_pkg:
  - arbiter state encodings (IDLE/GNT_M1/GNT_M2);
  - master-id constants NONE = 2'd0, M1 = 2'd1, M2 = 2'd2;
  - TIMEOUT default.
- One sub-module, hold_timer: the parameterised counter with clear, enable and an `expired` output.
- The FSM and split bookkeeping stay in bus_arbiter.

Test Plan:
- Reset, then m1_req = m2_req = 1 in cycle 0: m1_grant = 1 in cycle 1. m1_done in cycle 3 gives IDLE in cycle 4 and m2_grant = 1 in cycle 5.
- M2 granted, split in cycle 2: IDLE and split_allow = 0 in cycle 3. m2_req is ignored and m1_req is granted in cycle 4. split_ready in cycle 5 and m1_done in cycle 6 give IDLE in cycle 7 and m2_grant in cycle 8.
- TIMEOUT = 4, M1 granted with no done: IDLE after 4 granted cycles, timeout_err = 1 for exactly 1 cycle, and m1 is re-granted if m1_req is still high.
- M1 granted, m1_done and split in the same cycle: release with no split recorded (split_allow stays 1). Same check with done in the timeout cycle: timeout_err stays 0.
- split_ready with no split pending: no effect. A second split while pending: ignored, and the current grant continues.
- reset asserted while a split is pending and M1 is granted: all outputs return to reset values next cycle; a subsequent m2_req is granted immediately.
